// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 16-bit RAM port between the core RAM controller (0),
// the DMA engine (1) and video fetch (2).
// Registered one-hot grant, round-robin with optional core priority, bounded bursts,
// and per-requester read-valid tracking through a fixed RAM read latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, gnt = 0; arbitrate over req at every edge
// OWN   | gnt one-hot on the owner; count accesses, release on req drop
//       | or on the last access of the burst, re-arbitrating with no gap
module ram_port_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1,
    parameter int PRIO_CORE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  wr,
    input  logic [47:0] addr_in,
    input  logic [47:0] wdata_in,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [15:0] RAMaddr,
    output logic [15:0] toRAM,
    output logic        w,
    input  logic [15:0] fromRAM
);

    typedef enum logic [0:0] {IDLE, OWN} state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t      state;
    logic [7:0]  burst_cnt;
    logic [1:0]  last_owner;
    logic [1:0]  owner_idx;
    logic        access;
    logic        owner_release;
    logic [1:0]  win_idx;
    logic [2:0]  win_onehot;
    logic        rd_load;

    logic [RD_LAT-1:0] pipe_v;
    logic [1:0]        pipe_id [RD_LAT];

    // An access is a cycle where the owner still requests; write only when the owner says so.
    assign access        = |(gnt & req);
    assign w             = |(gnt & req & wr);
    assign rd_load       = access & ~w;
    assign owner_release = ~access | (burst_cnt == BURST_LAST);
    assign busy          = |gnt;
    assign rdata         = fromRAM;

    assign RAMaddr = ({16{gnt[0]}} & addr_in[15:0])
                   | ({16{gnt[1]}} & addr_in[31:16])
                   | ({16{gnt[2]}} & addr_in[47:32]);
    assign toRAM   = ({16{gnt[0]}} & wdata_in[15:0])
                   | ({16{gnt[1]}} & wdata_in[31:16])
                   | ({16{gnt[2]}} & wdata_in[47:32]);

    // Index of the current owner (only meaningful while gnt is non-zero).
    always_comb begin
        owner_idx = 2'd0;
        if (gnt[1])
            owner_idx = 2'd1;
        else if (gnt[2])
            owner_idx = 2'd2;
    end

    // Winner of an arbitration over the current requests: core first when prioritised,
    // else the first requester after last_owner in 0,1,2 order.
    always_comb begin
        win_idx = 2'd0;
        if ((PRIO_CORE != 0) && req[0]) begin
            win_idx = 2'd0;
        end else begin
            case (last_owner)
                2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
                2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
                default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
            endcase
        end
        case (win_idx)
            2'd0:    win_onehot = 3'b001;
            2'd1:    win_onehot = 3'b010;
            default: win_onehot = 3'b100;
        endcase
    end

    // Grant FSM: grant, burst counter and round-robin pointer move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 3'b000;
            burst_cnt  <= 8'd0;
            last_owner <= 2'd2;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= OWN;
                        gnt        <= win_onehot;
                        burst_cnt  <= 8'd0;
                        last_owner <= win_idx;
                    end
                end
                OWN: begin
                    if (owner_release) begin
                        burst_cnt <= 8'd0;
                        if (|req) begin
                            gnt        <= win_onehot;
                            last_owner <= win_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= 3'b000;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 3'b000;
                    burst_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Read tracking: carry {valid, owner} of each read access through the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int k = 0; k < RD_LAT; k++)
                pipe_id[k] <= 2'd0;
        end else begin
            pipe_v[0]  <= rd_load;
            pipe_id[0] <= owner_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end
        end
    end

    // Decode the pipeline tail into the per-requester read-valid pulse.
    always_comb begin
        rvalid = 3'b000;
        if (pipe_v[RD_LAT-1]) begin
            case (pipe_id[RD_LAT-1])
                2'd0:    rvalid = 3'b001;
                2'd1:    rvalid = 3'b010;
                default: rvalid = 3'b100;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: three instances with different parameter sets
// share the same stimulus; each scenario checks the instance it was written for.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [47:0] addr_in;
    logic [47:0] wdata_in;
    logic [15:0] from_ram;

    logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b, gnt_c, rvalid_c;
    logic [15:0] rdata_a, ramaddr_a, toram_a;
    logic [15:0] rdata_b, ramaddr_b, toram_b;
    logic [15:0] rdata_c, ramaddr_c, toram_c;
    logic        busy_a, w_a, busy_b, w_b, busy_c, w_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // A: defaults (burst 8, latency 1, round-robin)
    ram_port_arbiter #(.MAX_BURST(8), .RD_LAT(1), .PRIO_CORE(0)) dut_a (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .busy(busy_a),
        .RAMaddr(ramaddr_a), .toRAM(toram_a), .w(w_a), .fromRAM(from_ram));

    // B: short bursts, latency 3, round-robin
    ram_port_arbiter #(.MAX_BURST(2), .RD_LAT(3), .PRIO_CORE(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b),
        .RAMaddr(ramaddr_b), .toRAM(toram_b), .w(w_b), .fromRAM(from_ram));

    // C: short bursts, latency 1, core priority
    ram_port_arbiter #(.MAX_BURST(2), .RD_LAT(1), .PRIO_CORE(1)) dut_c (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .busy(busy_c),
        .RAMaddr(ramaddr_c), .toRAM(toram_c), .w(w_c), .fromRAM(from_ram));

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        req      = 3'b000;
        wr       = 3'b000;
        addr_in  = '0;
        wdata_in = '0;
        from_ram = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        req      = 3'b111;
        wr       = 3'b000;
        addr_in  = {16'h3333, 16'h2222, 16'h1111};
        wdata_in = {16'h6666, 16'h5555, 16'h4444};
        from_ram = 16'h0000;
        #3;
        tests++; if (gnt_a !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b expected 000", gnt_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL reset_rvalid: got %b expected 000", rvalid_a); end
        tests++; if (ramaddr_a !== 16'h0000) begin fails++; $display("FAIL reset_ramaddr: got %h expected 0000", ramaddr_a); end
        tests++; if (toram_a !== 16'h0000) begin fails++; $display("FAIL reset_toram: got %h expected 0000", toram_a); end
        tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL reset_w: got %b expected 0", w_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        req = 3'b000;
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick;
        tests++; if (gnt_a !== 3'b000) begin fails++; $display("FAIL idle_no_req_gnt: got %b expected 000", gnt_a); end
    endtask

    task automatic test_burst;
        do_reset;
        req     = 3'b010;
        wr      = 3'b000;
        addr_in = {16'h0000, 16'h0040, 16'h0000};
        #1;
        tests++; if (gnt_a !== 3'b000) begin fails++; $display("FAIL burst_latency: got %b expected 000", gnt_a); end
        for (int k = 0; k < 12; k++) begin
            tick;
            from_ram = 16'h1000 + 16'(k);
            #1;
            tests++; if (gnt_a !== 3'b010) begin fails++; $display("FAIL burst_gnt[%0d]: got %b expected 010", k, gnt_a); end
            tests++; if (ramaddr_a !== 16'h0040) begin fails++; $display("FAIL burst_ramaddr[%0d]: got %h expected 0040", k, ramaddr_a); end
            tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL burst_w[%0d]: got %b expected 0", k, w_a); end
            tests++; if (rvalid_a !== ((k >= 1) ? 3'b010 : 3'b000)) begin fails++; $display("FAIL burst_rvalid[%0d]: got %b expected %b", k, rvalid_a, (k >= 1) ? 3'b010 : 3'b000); end
            tests++; if (rdata_a !== from_ram) begin fails++; $display("FAIL burst_rdata[%0d]: got %h expected %h", k, rdata_a, from_ram); end
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_g [0:8];
        exp_g = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        do_reset;
        req = 3'b111;
        wr  = 3'b000;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick;
            #1;
            tests++; if (gnt_b !== exp_g[k]) begin fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_b, exp_g[k]); end
            tests++; if (busy_b !== (exp_g[k] != 3'b000)) begin fails++; $display("FAIL rr_busy[%0d]: got %b expected %b", k, busy_b, exp_g[k] != 3'b000); end
        end
    endtask

    task automatic test_write;
        do_reset;
        req      = 3'b101;
        wr       = 3'b001;
        addr_in  = {16'h0ABC, 16'h0000, 16'h1234};
        wdata_in = {16'h5555, 16'h0000, 16'hBEEF};
        #1;
        tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL wr_idle_w: got %b expected 0", w_a); end
        for (int k = 1; k <= 2; k++) begin
            tick;
            #1;
            tests++; if (gnt_a !== 3'b001) begin fails++; $display("FAIL wr_gnt[%0d]: got %b expected 001", k, gnt_a); end
            tests++; if (w_a !== 1'b1) begin fails++; $display("FAIL wr_w[%0d]: got %b expected 1", k, w_a); end
            tests++; if (toram_a !== 16'hBEEF) begin fails++; $display("FAIL wr_toram[%0d]: got %h expected beef", k, toram_a); end
            tests++; if (ramaddr_a !== 16'h1234) begin fails++; $display("FAIL wr_ramaddr[%0d]: got %h expected 1234", k, ramaddr_a); end
        end
        tick;
        req = 3'b100;
        #1;
        tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL wr_drop_w: got %b expected 0", w_a); end
        tests++; if (gnt_a !== 3'b001) begin fails++; $display("FAIL wr_drop_gnt: got %b expected 001", gnt_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL wr_drop_rvalid: got %b expected 000", rvalid_a); end
        tick;
        #1;
        tests++; if (gnt_a !== 3'b100) begin fails++; $display("FAIL wr_handover_gnt: got %b expected 100", gnt_a); end
        tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL wr_owner2_w: got %b expected 0", w_a); end
        tests++; if (ramaddr_a !== 16'h0ABC) begin fails++; $display("FAIL wr_owner2_ramaddr: got %h expected 0abc", ramaddr_a); end
        tests++; if (toram_a !== 16'h5555) begin fails++; $display("FAIL wr_owner2_toram: got %h expected 5555", toram_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL wr_owner2_rvalid: got %b expected 000", rvalid_a); end
        tick;
        #1;
        tests++; if (rvalid_a !== 3'b100) begin fails++; $display("FAIL wr_owner2_read_rvalid: got %b expected 100", rvalid_a); end
    endtask

    task automatic test_prio;
        logic [2:0]  exp_g [0:10];
        logic [2:0]  req_s [0:10];
        logic [2:0]  prev_acc;
        logic [15:0] exp_addr;
        exp_g = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
        req_s = '{3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110};
        do_reset;
        wr      = 3'b000;
        addr_in = {16'h2222, 16'h1111, 16'h0AAA};
        prev_acc = 3'b000;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick;
            req      = req_s[k];
            from_ram = 16'h7000 + 16'(k);
            #1;
            exp_addr = (exp_g[k] == 3'b001) ? 16'h0AAA :
                       (exp_g[k] == 3'b010) ? 16'h1111 :
                       (exp_g[k] == 3'b100) ? 16'h2222 : 16'h0000;
            tests++; if (gnt_c !== exp_g[k]) begin fails++; $display("FAIL prio_gnt[%0d]: got %b expected %b", k, gnt_c, exp_g[k]); end
            tests++; if (ramaddr_c !== exp_addr) begin fails++; $display("FAIL prio_ramaddr[%0d]: got %h expected %h", k, ramaddr_c, exp_addr); end
            tests++; if (rvalid_c !== prev_acc) begin fails++; $display("FAIL prio_rvalid[%0d]: got %b expected %b", k, rvalid_c, prev_acc); end
            tests++; if (w_c !== 1'b0) begin fails++; $display("FAIL prio_w[%0d]: got %b expected 0", k, w_c); end
            tests++; if (busy_c !== (exp_g[k] != 3'b000)) begin fails++; $display("FAIL prio_busy[%0d]: got %b expected %b", k, busy_c, exp_g[k] != 3'b000); end
            tests++; if (toram_c !== 16'h0000) begin fails++; $display("FAIL prio_toram[%0d]: got %h expected 0000", k, toram_c); end
            tests++; if (rdata_c !== from_ram) begin fails++; $display("FAIL prio_rdata[%0d]: got %h expected %h", k, rdata_c, from_ram); end
            prev_acc = exp_g[k] & req_s[k];
        end
    endtask

    task automatic test_read_latency;
        logic [2:0] exp_g [0:7];
        logic [2:0] exp_r [0:7];
        exp_g = '{3'b000, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        exp_r = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b100, 3'b000};
        do_reset;
        wr       = 3'b000;
        addr_in  = {16'h0222, 16'h0111, 16'h0000};
        wdata_in = {16'h9999, 16'h8888, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick;
            req      = (k < 4) ? 3'b110 : 3'b000;
            from_ram = 16'hA000 + 16'(k);
            #1;
            tests++; if (gnt_b !== exp_g[k]) begin fails++; $display("FAIL lat_gnt[%0d]: got %b expected %b", k, gnt_b, exp_g[k]); end
            tests++; if (rvalid_b !== exp_r[k]) begin fails++; $display("FAIL lat_rvalid[%0d]: got %b expected %b", k, rvalid_b, exp_r[k]); end
            tests++; if (w_b !== 1'b0) begin fails++; $display("FAIL lat_w[%0d]: got %b expected 0", k, w_b); end
            if (k == 3) begin
                tests++; if (ramaddr_b !== 16'h0222) begin fails++; $display("FAIL lat_ramaddr: got %h expected 0222", ramaddr_b); end
                tests++; if (toram_b !== 16'h9999) begin fails++; $display("FAIL lat_toram: got %h expected 9999", toram_b); end
            end
            if (k >= 4 && k <= 6) begin
                tests++; if (rdata_b !== from_ram) begin fails++; $display("FAIL lat_rdata[%0d]: got %h expected %h", k, rdata_b, from_ram); end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req     = 3'b010;
        wr      = 3'b000;
        addr_in = {16'h0000, 16'h0040, 16'h0000};
        tick;
        tick;
        tick;
        #1;
        tests++; if (gnt_a !== 3'b010) begin fails++; $display("FAIL rmid_pre_gnt: got %b expected 010", gnt_a); end
        tests++; if (rvalid_a !== 3'b010) begin fails++; $display("FAIL rmid_pre_rvalid: got %b expected 010", rvalid_a); end
        rst = 1'b1;
        #1;
        tests++; if (gnt_a !== 3'b000) begin fails++; $display("FAIL rmid_gnt: got %b expected 000", gnt_a); end
        tests++; if (ramaddr_a !== 16'h0000) begin fails++; $display("FAIL rmid_ramaddr: got %h expected 0000", ramaddr_a); end
        tests++; if (w_a !== 1'b0) begin fails++; $display("FAIL rmid_w: got %b expected 0", w_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL rmid_rvalid: got %b expected 000", rvalid_a); end
        tick;
        req = 3'b110;
        rst = 1'b0;
        #1;
        tests++; if (gnt_a !== 3'b000) begin fails++; $display("FAIL rmid_rel_gnt: got %b expected 000", gnt_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL rmid_rel_rvalid: got %b expected 000", rvalid_a); end
        tick;
        #1;
        tests++; if (gnt_a !== 3'b010) begin fails++; $display("FAIL rmid_first_gnt: got %b expected 010", gnt_a); end
        tests++; if (rvalid_a !== 3'b000) begin fails++; $display("FAIL rmid_first_rvalid: got %b expected 000", rvalid_a); end
    endtask

    initial begin
        test_reset;
        test_burst;
        test_round_robin;
        test_write;
        test_prio;
        test_read_latency;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single 16-bit RAM port (RAMaddr/toRAM/w/fromRAM) between three requesters: core RAM controller (0), DMA engine (1) and video fetch (2).
- Registered one-hot grant, round-robin with optional core priority.
- Bounded burst length per grant.
- Per-requester read-valid tracking through a fixed RAM read latency.
- Sits between the requesters and the RAM macro; requesters see only req/gnt/rvalid.

Parameters:
MAX_BURST, 8, max accesses per grant before forced re-arbitration (1..255)
RD_LAT, 1, cycles from read access cycle to fromRAM valid (1..4)
PRIO_CORE, 0, 1 = requester 0 wins every arbitration it takes part in; 0 = pure round-robin

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  3  per-requester access request, level; bit i = requester i
wr  in  3  per-requester write enable, meaningful while req[i]
addr_in  in  48  requester i address at [16i+15:16i]
wdata_in  in  48  requester i write data at [16i+15:16i]
gnt  out  3  registered one-hot grant (or 0)
rvalid  out  3  one-cycle pulse: rdata valid for requester i
rdata  out  16  fromRAM passed through combinationally
busy  out  1  |gnt
RAMaddr  out  16  RAM address
toRAM  out  16  RAM write data
w  out  1  RAM write strobe
fromRAM  in  16  RAM read data

Behaviour:
- Reset values: gnt=0, rvalid=0, burst counter=0, last_owner=2 (requester 0 first in round-robin order). RAMaddr, toRAM and w are 0 because gnt=0.
- Reset mid-operation: grant dropped, read pipeline flushed, so no rvalid follows reset. In-flight RAM reads are discarded.
- Access definition: a cycle with gnt[i]&req[i] is one access by i. w = access & wr[i].
- Datapath mux: RAMaddr/toRAM = owner's addr_in/wdata_in slice whenever gnt[i]; 0 when gnt=0.
- States:
  - IDLE (gnt=0).
  - OWN(i) (gnt=one-hot i).
  - Everything is decided at the clock edge from the current cycle's inputs.
- IDLE: if any req, select the winner; next cycle gnt=winner and counter=0. Otherwise stay IDLE. Latency from req rise to gnt is 1 cycle.
- OWN(i), stay: req[i]=1 and counter<MAX_BURST-1. On each access, counter+1.
- OWN(i), release, when either holds:
  - (a) req[i]=0 this cycle: no access, w=0.
  - (b) access with counter=MAX_BURST-1.
  - On release: run arbitration over current req with no dead cycle. New winner gets gnt next cycle, counter=0. No requester pending → IDLE.
- Arbitration:
  - PRIO_CORE=1 and req[0] → winner 0.
  - Otherwise round-robin: first requesting index after last_owner, order (last_owner+1) mod 3 upward.
  - last_owner updates to the winner.
- Burst exhaust with only the owner requesting: owner regranted, counter=0, no gap in accesses.
- Simultaneous req rise from all three in IDLE after reset: order 0,1,2 (PRIO_CORE=0).
- Read tracking: RD_LAT-deep shift register of {valid, owner id}, loaded each cycle with (access & ~wr). rvalid[id] pulses exactly RD_LAT cycles after the read access. Back-to-back reads give back-to-back pulses, including across a grant change.
- wr/addr_in/wdata_in of non-owners are ignored. Requesters must hold req until they see gnt. Dropping req before grant withdraws the request silently.

Test Plan:
- Reset, then req=3'b010 held, wr=0, addr1=16'h0040 → gnt=010 next cycle. RAMaddr=0040 for 8 cycles, then re-grant to 1 with no gap. rvalid[1] follows each access 1 cycle later (RD_LAT=1).
- req=3'b111 from IDLE after reset (PRIO_CORE=0, MAX_BURST=2) → gnt sequence 001,001,010,010,100,100,001…
- Owner 0 writes: wr0=1, addr0=16'h1234, wdata0=16'hBEEF, then req0 drops while req2 is high → w=1, toRAM=BEEF on access cycles. Cycle with req0=0: w=0. Next cycle gnt=100.
- PRIO_CORE=1, req=3'b110 with gnt on 1, then req0 rises → after 1's burst ends or req1 drops, gnt=001 every arbitration while req0 is held. 2 is served only when req0=0.
- RD_LAT=3: read by 1 at t, read by 2 at t+1 after handover → rvalid[1] at t+3, rvalid[2] at t+4, rdata=fromRAM.
- Assert rst during a 1-owned read burst → gnt=0, RAMaddr=0 and w=0 immediately. No rvalid pulses after release of rst. First grant after reset follows round-robin from requester 0.
